// File: rtl/mux41_arb_pkg.sv
// mux41_arb_pkg: shared state encodings, sizes and helpers for the 4-way mux arbiter
package mux41_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational rotating priority encoder, first set req bit at or after ptr
module rr_pick4
  import mux41_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);
  always_comb begin
    valid = |req;
    idx = ptr;
    // descending scan so the lowest rotated offset wins
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[ptr + SEL_W'(i)]) idx = ptr + SEL_W'(i);
  end
endmodule

// File: rtl/mux41_rr_arb.sv
// mux41_rr_arb: round-robin break-before-make arbiter driving a 4:1 enabled mux
// Define MUX41_ARB_TIMEOUT_EN to force release after MAX_HOLD cycles of ownership.
module mux41_rr_arb
  import mux41_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy
);
  state_t state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, pidx;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic pvalid, rel;
  if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_hold
    $error("MAX_HOLD out of range for CNT_W");
  end
  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pvalid),
    .idx  (pidx)
  );
`ifdef MUX41_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign rel = ~req[sel_q] | (cnt_q == CNT_W'(MAX_HOLD));
  always_comb
    cnt_d = (state_q == ST_IDLE)  ? (pvalid ? CNT_W'(1) : cnt_q) :
            (state_q == ST_GRANT) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign rel = ~req[sel_q];
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    gnt_d = gnt_q;
    case (state_q)
      ST_IDLE:
        if (pvalid) begin
          state_d = ST_GRANT;
          sel_d = pidx;
          gnt_d = onehot(pidx);
        end
      ST_GRANT:
        if (rel) begin
          state_d = ST_GAP;
          ptr_d = sel_q + SEL_W'(1);
          gnt_d = '0;
        end
      ST_GAP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        gnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      sel_q <= '0;
      gnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      gnt_q <= gnt_d;
    end
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign en = |gnt_q;
  assign busy = (state_q == ST_GRANT);
endmodule
